// File: rtl/fb_scanout.sv
// VGA-style scanout of the monochrome CHIP-8 framebuffer: raster counters, window
// fetch with 4x/8x pixel scaling, and a 3-stage pipeline that keeps pixel and syncs aligned.
module fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WIN_X0   = 64,
    parameter int WIN_Y0   = 112
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hires_i,
    input  logic [15:0] buf_out_i,
    output logic [8:0]  buf_addr_o,
    output logic        buf_enable_o,
    output logic        pixel_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WIN_W   = 512;
    localparam int WIN_H   = 256;
    // The window is clipped to the active area so it can never leak into blanking.
    localparam int WIN_X1  = (WIN_X0 + WIN_W < H_ACTIVE) ? WIN_X0 + WIN_W : H_ACTIVE;
    localparam int WIN_Y1  = (WIN_Y0 + WIN_H < V_ACTIVE) ? WIN_Y0 + WIN_H : V_ACTIVE;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HA_L     = 10'(H_ACTIVE);
    localparam logic [9:0] VA_L     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG_L = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END_L = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG_L = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END_L = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WX0_L    = 10'(WIN_X0);
    localparam logic [9:0] WX1_L    = 10'(WIN_X1);
    localparam logic [9:0] WY0_L    = 10'(WIN_Y0);
    localparam logic [9:0] WY1_L    = 10'(WIN_Y1);

    typedef struct packed {
        logic       win;
        logic [3:0] bsel;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
    } stage_t;

    typedef struct packed {
        logic pix;
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } out_t;

    localparam stage_t STAGE_RST = '{win: 1'b0, bsel: 4'd0, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
    localparam out_t   OUT_RST   = '{pix: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       hires_l_q, hires_l_d;
    logic [8:0] addr_q, addr_d;
    stage_t     s1_q, s1_d;
    out_t       s2_q, s2_d;

    logic       in_win;
    logic [6:0] wx_q4;
    logic [5:0] wy_q4;
    logic [8:0] addr_s0;
    logic [3:0] bsel_s0;

    // ---------------- S0: raster counters, mode latch, window decode ----------------
    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end
    end

    assign hires_l_d = (hcnt_q == '0 && vcnt_q == '0) ? hires_i : hires_l_q;

    assign in_win = (hcnt_q >= WX0_L) && (hcnt_q < WX1_L) &&
                    (vcnt_q >= WY0_L) && (vcnt_q < WY1_L);

    // Window coordinates pre-divided by 4; lores drops one more bit for its 8x scale.
    assign wx_q4 = 7'((hcnt_q - WX0_L) >> 2);
    assign wy_q4 = 6'((vcnt_q - WY0_L) >> 2);

    always_comb begin
        if (hires_l_q) begin
            addr_s0 = {wy_q4, wx_q4[6:4]};
            bsel_s0 = wx_q4[3:0];
        end else begin
            addr_s0 = {2'b00, wy_q4[5:1], wx_q4[6:5]};
            bsel_s0 = wx_q4[4:1];
        end
    end

    // The address port parks on the last fetched word outside the window.
    assign addr_d       = in_win ? addr_s0 : addr_q;
    assign buf_addr_o   = addr_d;
    assign buf_enable_o = in_win;

    always_comb begin
        s1_d      = STAGE_RST;
        s1_d.win  = in_win;
        s1_d.bsel = bsel_s0;
        s1_d.de   = (hcnt_q < HA_L) && (vcnt_q < VA_L);
        s1_d.hs   = !((hcnt_q >= HS_BEG_L) && (hcnt_q < HS_END_L));
        s1_d.vs   = !((vcnt_q >= VS_BEG_L) && (vcnt_q < VS_END_L));
        s1_d.fs   = (hcnt_q == '0) && (vcnt_q == VA_L);
    end

    // ---------------- S2: pixel select and output registers ----------------
    always_comb begin
        s2_d     = OUT_RST;
        s2_d.pix = s1_q.win ? buf_out_i[~s1_q.bsel] : 1'b0;
        s2_d.de  = s1_q.de;
        s2_d.hs  = s1_q.hs;
        s2_d.vs  = s1_q.vs;
        s2_d.fs  = s1_q.fs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hires_l_q <= 1'b0;
            addr_q    <= '0;
            s1_q      <= STAGE_RST;
            s2_q      <= OUT_RST;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hires_l_q <= hires_l_d;
            addr_q    <= addr_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
        end
    end

    assign pixel_o       = s2_q.pix;
    assign de_o          = s2_q.de;
    assign hsync_o       = s2_q.hs;
    assign vsync_o       = s2_q.vs;
    assign frame_start_o = s2_q.fs;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a shortened raster (same 512x256 window logic,
// clipped vertically) so that several whole frames fit in a short run.
module tb_fb_scanout;

    localparam int HA  = 520;
    localparam int HF  = 4;
    localparam int HS  = 8;
    localparam int HB  = 4;
    localparam int VA  = 12;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int WX0 = 4;
    localparam int WY0 = 2;
    localparam int HT  = HA + HF + HS + HB;   // 536
    localparam int VT  = VA + VF + VS + VB;   // 17
    localparam int FR  = HT * VT;             // 9112
    localparam int WX1 = WX0 + 512;           // 516, inside active width
    localparam int WY1 = VA;                  // window clipped at last active line

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hires = 1'b0;
    logic [15:0] buf_out = 16'h0;
    logic [8:0]  buf_addr;
    logic        buf_enable, pixel, de, hsync, vsync, frame_start;
    logic [15:0] mem [0:511];

    int nvec = 0;
    int nerr = 0;
    int k = 0;
    int fs_cnt = 0;
    int de_cnt = 0;

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .WIN_X0(WX0), .WIN_Y0(WY0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hires_i(hires), .buf_out_i(buf_out),
        .buf_addr_o(buf_addr), .buf_enable_o(buf_enable), .pixel_o(pixel),
        .de_o(de), .hsync_o(hsync), .vsync_o(vsync), .frame_start_o(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (buf_enable) buf_out <= mem[buf_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 512; i++) mem[i] = v;
    endtask

    task automatic do_reset(input logic hr);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        hires = hr;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pixel"}, {31'd0, pixel}, 0);
        chk({tag, "_de"}, {31'd0, de}, 0);
        chk({tag, "_hsync"}, {31'd0, hsync}, 1);
        chk({tag, "_vsync"}, {31'd0, vsync}, 1);
        chk({tag, "_frame_start"}, {31'd0, frame_start}, 0);
        chk({tag, "_buf_enable"}, {31'd0, buf_enable}, 0);
        chk({tag, "_buf_addr"}, {23'd0, buf_addr}, 0);
    endtask

    // Hand-derived lit regions for each directed RAM image.
    function automatic logic exp_pix(input int t, input int p);
        int h, v, f;
        h = p % HT;
        v = (p / HT) % VT;
        f = p / FR;
        case (t)
            0: return (h >= WX0 && h < WX0 + 4 && v >= WY0 && v < WY0 + 4);
            1: return (h >= WX0 + 504 && h < WX0 + 512 && v >= WY0 && v < WY0 + 8);
            2: if (f == 0) return (h >= WX0 && h < WX0 + 8 && v >= WY0 && v < WY0 + 8);
               else        return (h >= WX0 && h < WX0 + 4 && v >= WY0 && v < WY0 + 4);
            default: return (h >= WX0 && h < WX1 && v >= WY0 && v < WY1);
        endcase
    endfunction

    task automatic check_cycle(input int t);
        int p, h, v, hc, vc;
        logic e_de, e_hs, e_vs, e_fs, e_px, e_win;
        if (k >= 2) begin
            p    = k - 2;
            h    = p % HT;
            v    = (p / HT) % VT;
            e_de = (h < HA) && (v < VA);
            e_hs = !(h >= HA + HF && h < HA + HF + HS);
            e_vs = !(v >= VA + VF && v < VA + VF + VS);
            e_fs = (h == 0) && (v == VA);
            e_px = exp_pix(t, p);
        end else begin
            e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_px = 1'b0;
        end
        chk("de", {31'd0, de}, {31'd0, e_de});
        chk("hsync", {31'd0, hsync}, {31'd0, e_hs});
        chk("vsync", {31'd0, vsync}, {31'd0, e_vs});
        chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
        chk("pixel", {31'd0, pixel}, {31'd0, e_px});
        hc    = k % HT;
        vc    = (k / HT) % VT;
        e_win = (hc >= WX0) && (hc < WX1) && (vc >= WY0) && (vc < WY1);
        chk("buf_enable", {31'd0, buf_enable}, {31'd0, e_win});
        if (hc == WX0 && vc == WY0)
            chk("buf_addr_origin", {23'd0, buf_addr}, 0);
        if (t == 0 && hc == WX1 + 10 && vc >= WY0 && vc < WY1)
            chk("buf_addr_hold_hires", {23'd0, buf_addr}, 8 * ((vc - WY0) >> 2) + 7);
        if (t == 1 && hc == WX1 + 10 && vc >= WY0 && vc < WY1)
            chk("buf_addr_hold_lores", {23'd0, buf_addr}, 4 * ((vc - WY0) >> 3) + 3);
        if (t == 1 && buf_enable)
            chk("buf_addr_lores_max", {31'd0, (int'(buf_addr) <= 127)}, 1);
        if (frame_start) fs_cnt++;
        if (de) de_cnt++;
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        fill(16'h0000);
        mem[0] = 16'h8000;
        hires = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");

        // Timing over two frames plus hires mapping of word 0
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        fs_cnt = 0;
        de_cnt = 0;
        repeat (2 * FR) begin
            tick();
            check_cycle(0);
        end
        chk("frame_start_count", fs_cnt, 2);
        chk("de_count", de_cnt, 2 * HA * VA);

        // Lores mapping: rightmost pixel of word 3
        fill(16'h0000);
        mem[3] = 16'h0001;
        do_reset(1'b0);
        repeat (FR) begin
            tick();
            check_cycle(1);
        end

        // Mode latch: hires raised mid-frame applies from the next frame
        fill(16'h0000);
        mem[0] = 16'h8000;
        do_reset(1'b0);
        repeat (2 * FR) begin
            tick();
            check_cycle(2);
            if (k == (WY0 + 2) * HT) hires = 1'b1;
        end

        // Border/blanking with a fully lit framebuffer, then reset mid-frame
        fill(16'hFFFF);
        do_reset(1'b1);
        while (k < 6 * HT + 100) begin
            tick();
            check_cycle(3);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 2000 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (hsync === 1'b0) seen = 1'b1;
        end
        chk("hsync_after_reset", n, HA + HF + 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
